num_smul_pipe: RTL and testbench
================================

NUM_SMUL_PIPE -- requirements
Module: num_smul_pipe

Interface
REQ-001 SHALL have parameter LEFT_WIDTH, default 32: signed left operand width.
REQ-002 SHALL have parameter RIGHT_WIDTH, default 32: signed right operand width.
REQ-003 SHALL have parameter OUT_WIDTH, default 32: signed result width.
REQ-004 SHALL have parameter OUT_LSB, default 0: product bit mapped to out[0], i.e. arithmetic right-shift amount, 0..LEFT_WIDTH+RIGHT_WIDTH-1.
REQ-005 SHALL have parameter LATENCY, default 3: cycles from accepted go to done, legal range 2..8.
REQ-006 SHALL have parameter ROUND, default 0: 0 = truncate (floor), 1 = round-half-up.
REQ-007 SHALL have parameter SATURATE, default 0: 0 = wrap, 1 = clamp to signed OUT_WIDTH range.
REQ-008 SHALL have port clk, input, 1 bit: the single clock; all state on posedge.
REQ-009 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-010 SHALL have port go, input, 1 bit: start request, held high by the controller until done.
REQ-011 SHALL have port left, input, LEFT_WIDTH bits: signed operand.
REQ-012 SHALL have port right, input, RIGHT_WIDTH bits: signed operand.
REQ-013 SHALL have port out, output, OUT_WIDTH bits: registered signed result.
REQ-014 SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY, DONE, plus a cycle counter sized for LATENCY.
REQ-016 SHALL, in IDLE with go=1 at cycle t, capture left/right into operand registers and enter BUSY.
REQ-017 SHALL assert done=1 at cycle t+LATENCY only (state DONE), for exactly one cycle.
REQ-018 SHALL update out on the edge that enters DONE, then hold out unchanged until the next completion or reset.
REQ-019 SHALL form the full signed product P of LEFT_WIDTH+RIGHT_WIDTH bits, with no intermediate truncation.
REQ-020 SHALL, when ROUND=1 and OUT_LSB>0, add 2^(OUT_LSB-1) to P in a width one bit wider before shifting; otherwise add nothing.
REQ-021 SHALL arithmetic-shift the (rounded) product right by OUT_LSB.
REQ-022 SHALL, when SATURATE=1, clamp a shifted value above 2^(OUT_WIDTH-1)-1 or below -2^(OUT_WIDTH-1) to that bound.
REQ-023 SHALL, when SATURATE=0, output the low OUT_WIDTH bits of the shifted value.
REQ-024 SHALL sign-extend the shifted value when OUT_WIDTH exceeds its width.
REQ-025 SHALL distribute the multiply and round/saturate across LATENCY-1 register stages after operand capture.
REQ-026 SHALL go DONE -> IDLE unconditionally; go=1 in the cycle after done starts a new operation (back-to-back period LATENCY+1).
REQ-027 SHALL, if go falls while BUSY, abort: return to IDLE next edge, no done, out unchanged.
REQ-028 SHALL ignore left/right changes after the capture cycle.

Reset
REQ-029 SHALL, on reset=1 at a posedge, force state IDLE, counter 0, done=0, out=0, and operand and pipeline registers 0.
REQ-030 SHALL give reset priority over go in the same cycle; no operation starts.
REQ-031 SHALL, on reset mid-operation, discard the operation with no done pulse afterwards.

Structure
REQ-032 SHALL take the FSM state typedef and ROUND_TRUNC/ROUND_HALF_UP constants from shared package num_pkg.
REQ-033 SHALL place shift/round/saturate in combinational sub-module num_sround_sat (params IN_WIDTH, OUT_WIDTH, SHIFT, ROUND, SATURATE), reusable by future primitives.

Verification (LEFT=RIGHT=OUT_WIDTH=8, OUT_LSB=4, LATENCY=3 unless stated)
REQ-034 SHALL cover: left=0x18, right=0x20, go at t -> done only at t+3, out=0x30; out held after done.
REQ-035 SHALL cover: SATURATE=1, 0x7F*0x7F -> 0x7F; 0x80*0x7F -> 0x80; SATURATE=0, 0x7F*0x7F -> 0xF0.
REQ-036 SHALL cover: 0x01*0x08 -> 0x00 (ROUND=0), 0x01 (ROUND=1); 0xFF*0x08 -> 0xFF (ROUND=0), 0x00 (ROUND=1).
REQ-037 SHALL cover: go held high across two operations -> done pulses at t+3 and t+7, each result correct.
REQ-038 SHALL cover: reset at t+2 of an operation -> no done, out=0x00; go dropped at t+1 -> no done, out retains prior value.
REQ-039 SHALL cover: LATENCY=2 and LATENCY=8 -> done exactly at t+2 and t+8.

Source files
------------

// File: rtl/num_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// num_pkg : shared types and constants for the num_* arithmetic primitives
// Rev 1.0
// ---------------------------------------------------------------------------
package num_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } smul_state_t;

   localparam int ROUND_TRUNC   = 0;
   localparam int ROUND_HALF_UP = 1;

endpackage
`default_nettype wire

// File: rtl/num_sround_sat.sv
`default_nettype none
// ---------------------------------------------------------------------------
// num_sround_sat : arithmetic right shift with optional round-half-up and saturation
// Rev 1.0
// ---------------------------------------------------------------------------
module num_sround_sat
   import num_pkg::*;
#(
   parameter int IN_WIDTH  = 64,
   parameter int OUT_WIDTH = 32,
   parameter int SHIFT     = 0,
   parameter int ROUND     = ROUND_TRUNC,
   parameter int SATURATE  = 0
) (
   input  logic signed [IN_WIDTH-1:0]  i_din,
   output logic signed [OUT_WIDTH-1:0] o_dout
);

   // One guard bit so the rounding increment can never overflow.
   localparam int EXT_W  = IN_WIDTH + 1;
   localparam int WIDE_W = ((EXT_W > OUT_WIDTH) ? EXT_W : OUT_WIDTH) + 1;

   localparam logic signed [WIDE_W-1:0] C_MAX =
      {{(WIDE_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [WIDE_W-1:0] C_MIN =
      {{(WIDE_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

   logic signed [EXT_W-1:0]  w_ext;
   logic signed [EXT_W-1:0]  w_rnd;
   logic signed [EXT_W-1:0]  w_shf;
   logic signed [WIDE_W-1:0] w_wide;

   assign w_ext = {i_din[IN_WIDTH-1], i_din};

   generate
      if (ROUND == ROUND_HALF_UP && SHIFT > 0) begin : g_round
         localparam logic [EXT_W-1:0] C_HALF = EXT_W'(1) << (SHIFT - 1);
         assign w_rnd = w_ext + $signed(C_HALF);
      end else begin : g_trunc
         assign w_rnd = w_ext;
      end
   endgenerate

   assign w_shf  = w_rnd >>> SHIFT;
   assign w_wide = {{(WIDE_W-EXT_W){w_shf[EXT_W-1]}}, w_shf};

   generate
      if (SATURATE != 0) begin : g_sat
         always_comb begin
            o_dout = w_wide[OUT_WIDTH-1:0];
            if (w_wide > C_MAX) begin
               o_dout = C_MAX[OUT_WIDTH-1:0];
            end else if (w_wide < C_MIN) begin
               o_dout = C_MIN[OUT_WIDTH-1:0];
            end
         end
      end else begin : g_wrap
         logic w_unused_hi;
         assign w_unused_hi = ^w_wide;
         assign o_dout      = w_wide[OUT_WIDTH-1:0];
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/num_smul_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// num_smul_pipe : go/done sequenced, pipelined signed multiply with shift/round/saturate
// Rev 1.0
// ---------------------------------------------------------------------------
module num_smul_pipe
   import num_pkg::*;
#(
   parameter int LEFT_WIDTH  = 32,
   parameter int RIGHT_WIDTH = 32,
   parameter int OUT_WIDTH   = 32,
   parameter int OUT_LSB     = 0,
   parameter int LATENCY     = 3,
   parameter int ROUND       = ROUND_TRUNC,
   parameter int SATURATE    = 0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   go,
   input  logic [LEFT_WIDTH-1:0]  left,
   input  logic [RIGHT_WIDTH-1:0] right,
   output logic [OUT_WIDTH-1:0]   out,
   output logic                   done
);

   localparam int PROD_W = LEFT_WIDTH + RIGHT_WIDTH;
   localparam int NPIPE  = LATENCY - 2;
   localparam int CNT_W  = $clog2(LATENCY + 1);
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(LATENCY - 2);

   smul_state_t                    r_state;
   logic [CNT_W-1:0]               r_cnt;
   logic signed [LEFT_WIDTH-1:0]   r_left;
   logic signed [RIGHT_WIDTH-1:0]  r_right;
   logic signed [PROD_W-1:0]       w_prod;
   logic signed [PROD_W-1:0]       w_tail;
   logic signed [OUT_WIDTH-1:0]    w_res;

   assign w_prod = $signed({{RIGHT_WIDTH{r_left[LEFT_WIDTH-1]}}, r_left}) *
                   $signed({{LEFT_WIDTH{r_right[RIGHT_WIDTH-1]}}, r_right});

   // Product delay line; the final stage is the out register itself.
   generate
      if (NPIPE > 0) begin : g_pipe
         logic signed [PROD_W-1:0] r_pipe [NPIPE];
         always_ff @(posedge clk) begin
            if (reset) begin
               for (int i = 0; i < NPIPE; i++) r_pipe[i] <= '0;
            end else if (r_state == BUSY) begin
               r_pipe[0] <= w_prod;
               for (int i = 1; i < NPIPE; i++) r_pipe[i] <= r_pipe[i-1];
            end
         end
         assign w_tail = r_pipe[NPIPE-1];
      end else begin : g_nopipe
         assign w_tail = w_prod;
      end
   endgenerate

   num_sround_sat #(
      .IN_WIDTH  (PROD_W),
      .OUT_WIDTH (OUT_WIDTH),
      .SHIFT     (OUT_LSB),
      .ROUND     (ROUND),
      .SATURATE  (SATURATE)
   ) u_sround_sat (
      .i_din  (w_tail),
      .o_dout (w_res)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_left  <= '0;
         r_right <= '0;
         out     <= '0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (go) begin
                  r_left  <= left;
                  r_right <= right;
                  r_cnt   <= '0;
                  r_state <= BUSY;
               end
            end
            BUSY: begin
               // Dropping go mid-flight abandons the operation silently.
               if (!go) begin
                  r_state <= IDLE;
               end else if (r_cnt == C_LAST) begin
                  r_state <= DONE;
                  done    <= 1'b1;
                  out     <= w_res;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_num_smul_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_num_smul_pipe : randomized self-checking bench, four parameter variants
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_num_smul_pipe;

   localparam int NDUT = 4;
   localparam int LAT_K [NDUT] = '{3, 3, 2, 8};
   localparam int RND_K [NDUT] = '{0, 1, 1, 0};
   localparam int SAT_K [NDUT] = '{0, 1, 0, 1};

   logic       clk;
   logic       reset;
   logic       go     [NDUT];
   logic [7:0] left;
   logic [7:0] right;
   logic [7:0] out_v  [NDUT];
   logic       done_v [NDUT];

   int n_checks;
   int n_errors;
   int last_out [NDUT];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   num_smul_pipe #(.LEFT_WIDTH(8), .RIGHT_WIDTH(8), .OUT_WIDTH(8), .OUT_LSB(4),
                   .LATENCY(3), .ROUND(0), .SATURATE(0))
   u_dut0 (.clk(clk), .reset(reset), .go(go[0]), .left(left), .right(right),
           .out(out_v[0]), .done(done_v[0]));

   num_smul_pipe #(.LEFT_WIDTH(8), .RIGHT_WIDTH(8), .OUT_WIDTH(8), .OUT_LSB(4),
                   .LATENCY(3), .ROUND(1), .SATURATE(1))
   u_dut1 (.clk(clk), .reset(reset), .go(go[1]), .left(left), .right(right),
           .out(out_v[1]), .done(done_v[1]));

   num_smul_pipe #(.LEFT_WIDTH(8), .RIGHT_WIDTH(8), .OUT_WIDTH(8), .OUT_LSB(4),
                   .LATENCY(2), .ROUND(1), .SATURATE(0))
   u_dut2 (.clk(clk), .reset(reset), .go(go[2]), .left(left), .right(right),
           .out(out_v[2]), .done(done_v[2]));

   num_smul_pipe #(.LEFT_WIDTH(8), .RIGHT_WIDTH(8), .OUT_WIDTH(8), .OUT_LSB(4),
                   .LATENCY(8), .ROUND(0), .SATURATE(1))
   u_dut3 (.clk(clk), .reset(reset), .go(go[3]), .left(left), .right(right),
           .out(out_v[3]), .done(done_v[3]));

   task automatic check_val(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference: exact product, optional +8, floor divide by 16, clamp or wrap to 8 bits.
   function automatic int ref_mul(input logic [7:0] a, input logic [7:0] b,
                                  input int rnd, input int sat);
      int sa;
      int sb;
      int p;
      sa = $signed(a);
      sb = $signed(b);
      p  = sa * sb;
      if (rnd != 0) p = p + 8;
      p = p >>> 4;
      if (sat != 0) begin
         if (p > 127) p = 127;
         else if (p < -128) p = -128;
      end
      return p & 255;
   endfunction

   task automatic do_op(input int k, input logic [7:0] a, input logic [7:0] b,
                        output int got);
      int first;
      int pulses;
      int exp;
      exp    = ref_mul(a, b, RND_K[k], SAT_K[k]);
      first  = -1;
      pulses = 0;
      got    = -1;
      @(negedge clk);
      left  = a;
      right = b;
      go[k] = 1'b1;
      for (int c = 1; c <= LAT_K[k] + 3; c++) begin
         @(posedge clk);
         #1;
         left  = 8'($urandom);
         right = 8'($urandom);
         if (done_v[k]) begin
            pulses++;
            if (first < 0) begin
               first = c;
               got   = int'(out_v[k]);
            end
            go[k] = 1'b0;
         end
      end
      go[k] = 1'b0;
      check_val($sformatf("done_cycle%0d", k), first, LAT_K[k]);
      check_val($sformatf("done_pulses%0d", k), pulses, 1);
      check_val($sformatf("result%0d", k), got, exp);
      check_val($sformatf("out_held%0d", k), int'(out_v[k]), exp);
      last_out[k] = exp;
   endtask

   task automatic back_to_back(input logic [7:0] a1, input logic [7:0] b1,
                               input logic [7:0] a2, input logic [7:0] b2);
      int d1, d2, pulses, o1, o2;
      d1 = -1; d2 = -1; pulses = 0; o1 = -1; o2 = -1;
      @(negedge clk);
      left  = a1;
      right = b1;
      go[0] = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk);
         #1;
         left  = a2;
         right = b2;
         if (done_v[0]) begin
            pulses++;
            if (pulses == 1) begin
               d1 = c;
               o1 = int'(out_v[0]);
            end else if (pulses == 2) begin
               d2 = c;
               o2 = int'(out_v[0]);
               go[0] = 1'b0;
            end
         end
      end
      go[0] = 1'b0;
      check_val("b2b_first_cycle", d1, 3);
      check_val("b2b_second_cycle", d2, 7);
      check_val("b2b_pulses", pulses, 2);
      check_val("b2b_result1", o1, ref_mul(a1, b1, 0, 0));
      check_val("b2b_result2", o2, ref_mul(a2, b2, 0, 0));
      last_out[0] = ref_mul(a2, b2, 0, 0);
   endtask

   task automatic abort_op(input int k, input logic [7:0] a, input logic [7:0] b);
      int pulses;
      pulses = 0;
      @(negedge clk);
      left  = a;
      right = b;
      go[k] = 1'b1;
      @(posedge clk);
      #1;
      go[k] = 1'b0;
      for (int c = 2; c <= LAT_K[k] + 4; c++) begin
         @(posedge clk);
         #1;
         if (done_v[k]) pulses++;
      end
      check_val($sformatf("abort_pulses%0d", k), pulses, 0);
      check_val($sformatf("abort_out%0d", k), int'(out_v[k]), last_out[k]);
   endtask

   task automatic reset_mid(input int k, input logic [7:0] a, input logic [7:0] b);
      int pulses;
      pulses = 0;
      @(negedge clk);
      left  = a;
      right = b;
      go[k] = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      go[k] = 1'b0;
      for (int c = 0; c < LAT_K[k] + 4; c++) begin
         @(posedge clk);
         #1;
         if (done_v[k]) pulses++;
      end
      check_val($sformatf("rst_pulses%0d", k), pulses, 0);
      for (int j = 0; j < NDUT; j++) begin
         check_val($sformatf("rst_out%0d", j), int'(out_v[j]), 0);
         last_out[j] = 0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int got;
      int k;
      n_checks = 0;
      n_errors = 0;
      reset    = 1'b1;
      left     = '0;
      right    = '0;
      for (int j = 0; j < NDUT; j++) begin
         go[j]       = 1'b0;
         last_out[j] = 0;
      end
      go[0] = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      for (int j = 0; j < NDUT; j++) begin
         check_val($sformatf("reset_out%0d", j), int'(out_v[j]), 0);
         check_val($sformatf("reset_done%0d", j), int'(done_v[j]), 0);
      end
      go[0] = 1'b0;
      reset = 1'b0;

      do_op(0, 8'h18, 8'h20, got); check_val("basic_0x18x0x20", got, 8'h30);
      do_op(1, 8'h7F, 8'h7F, got); check_val("sat_pos", got, 8'h7F);
      do_op(1, 8'h80, 8'h7F, got); check_val("sat_neg", got, 8'h80);
      do_op(0, 8'h7F, 8'h7F, got); check_val("wrap_pos", got, 8'hF0);
      do_op(0, 8'h01, 8'h08, got); check_val("trunc_pos", got, 8'h00);
      do_op(1, 8'h01, 8'h08, got); check_val("round_pos", got, 8'h01);
      do_op(0, 8'hFF, 8'h08, got); check_val("trunc_neg", got, 8'hFF);
      do_op(1, 8'hFF, 8'h08, got); check_val("round_neg", got, 8'h00);

      back_to_back(8'h18, 8'h20, 8'hC3, 8'h5A);
      abort_op(0, 8'h11, 8'h22);
      reset_mid(0, 8'h7F, 8'h33);

      do_op(2, 8'h35, 8'hE7, got);
      do_op(3, 8'h7F, 8'h7F, got);
      do_op(3, 8'h9C, 8'h41, got);

      for (int n = 0; n < 40; n++) begin
         k = int'($urandom_range(0, NDUT - 1));
         if ($urandom_range(0, 7) == 0) begin
            abort_op(k, 8'($urandom), 8'($urandom));
         end else begin
            do_op(k, 8'($urandom), 8'($urandom), got);
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
